// File: rtl/pipe_ctrl_sched.sv
// Stall/flush scheduler for the 5-stage RV32 pipeline: memory freeze, redirect, load-use and refill.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl_sched #(
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned REFILL_BUBBLES = 1
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W          = 32
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load_use,
  input  logic i_mispredict,
  input  logic i_dmem_req,
  input  logic i_dmem_ack,
  output logic o_stall_pc,
  output logic o_stall_if_id,
  output logic o_stall_id_ex,
  output logic o_stall_ex_mem,
  output logic o_flush_if_id,
  output logic o_flush_id_ex,
  output logic o_flush_mem_wb,
  output logic o_redirect,
  output logic o_mem_err,
  output logic o_busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt_load_use,
  output logic [CNT_W-1:0] o_cnt_mispredict,
  output logic [CNT_W-1:0] o_cnt_mem_wait
`endif
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);
  localparam int unsigned RCNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REFILL   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WCNT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [RCNT_W-1:0]   r_refill_cnt, w_refill_nxt;
  logic                r_rst_q;

  logic w_quiet, w_freeze, w_wdog;
  logic w_stall_pc, w_stall_if_id, w_stall_id_ex, w_stall_ex_mem;
  logic w_flush_if_id, w_flush_id_ex, w_flush_mem_wb;
  logic w_redirect, w_mem_err, w_busy;

  // State and counter registers; r_rst_q marks the quiet cycle right after reset
  always_ff @(posedge i_clk) begin
    r_rst_q <= i_reset;
    if (i_reset) begin
      r_state      <= ST_RUN;
      r_wait_cnt   <= '0;
      r_refill_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_refill_cnt <= w_refill_nxt;
    end
  end

  // Priority: watchdog release > memory freeze > mispredict > load-use > refill flush
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_refill_nxt   = r_refill_cnt;
    w_freeze       = 1'b0;
    w_wdog         = 1'b0;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_stall_ex_mem = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_mem_wb = 1'b0;
    w_redirect     = 1'b0;
    w_mem_err      = 1'b0;
    w_busy         = 1'b0;
    w_quiet        = i_reset | r_rst_q;

    if (!w_quiet) begin
      w_busy   = (r_state != ST_RUN);
      w_freeze = (r_state == ST_MEM_WAIT) ? ~i_dmem_ack : (i_dmem_req & ~i_dmem_ack);
      w_wdog   = (r_state == ST_MEM_WAIT) & ~i_dmem_ack &
                 (r_wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));

      if (w_wdog) begin
        w_mem_err   = 1'b1;
        w_state_nxt = ST_RUN;
      end else if (w_freeze) begin
        w_stall_pc     = 1'b1;
        w_stall_if_id  = 1'b1;
        w_stall_id_ex  = 1'b1;
        w_stall_ex_mem = 1'b1;
        w_flush_mem_wb = 1'b1;
        w_state_nxt    = ST_MEM_WAIT;
        w_wait_nxt     = (r_state == ST_MEM_WAIT) ? r_wait_cnt + WCNT_W'(1) : '0;
      end else if (i_mispredict) begin
        w_redirect    = 1'b1;
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
        if (REFILL_BUBBLES > 0) begin
          w_state_nxt  = ST_REFILL;
          w_refill_nxt = RCNT_W'(REFILL_BUBBLES);
        end else begin
          w_state_nxt  = ST_RUN;
        end
      end else if (i_load_use) begin
        // A load-use stall defers the pending refill bubble rather than consuming it
        w_stall_pc    = 1'b1;
        w_stall_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
        w_state_nxt   = (r_state == ST_REFILL) ? ST_REFILL : ST_RUN;
      end else if (r_state == ST_REFILL) begin
        w_flush_if_id = 1'b1;
        if (r_refill_cnt <= RCNT_W'(1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_refill_nxt = r_refill_cnt - RCNT_W'(1);
        end
      end else begin
        w_state_nxt = ST_RUN;
      end
    end
  end

  assign o_stall_pc     = w_stall_pc;
  assign o_stall_if_id  = w_stall_if_id;
  assign o_stall_id_ex  = w_stall_id_ex;
  assign o_stall_ex_mem = w_stall_ex_mem;
  assign o_flush_if_id  = w_flush_if_id;
  assign o_flush_id_ex  = w_flush_id_ex;
  assign o_flush_mem_wb = w_flush_mem_wb;
  assign o_redirect     = w_redirect;
  assign o_mem_err      = w_mem_err;
  assign o_busy         = w_busy;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_lu, r_cnt_mp, r_cnt_mw;
  logic             w_lu_hit;

  assign w_lu_hit = w_stall_pc & ~w_flush_mem_wb;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt_lu <= '0;
      r_cnt_mp <= '0;
      r_cnt_mw <= '0;
    end else begin
      if (w_lu_hit && (r_cnt_lu != '1))       r_cnt_lu <= r_cnt_lu + CNT_W'(1);
      if (w_redirect && (r_cnt_mp != '1))     r_cnt_mp <= r_cnt_mp + CNT_W'(1);
      if (w_flush_mem_wb && (r_cnt_mw != '1)) r_cnt_mw <= r_cnt_mw + CNT_W'(1);
    end
  end

  assign o_cnt_load_use   = r_cnt_lu;
  assign o_cnt_mispredict = r_cnt_mp;
  assign o_cnt_mem_wait   = r_cnt_mw;
`endif

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Testbench for pipe_ctrl_sched: directed vector table, corner sequences, and random stimulus vs. a reference model.
module tb_pipe_ctrl_sched;

  localparam int unsigned MEM_TIMEOUT    = 16;
  localparam int unsigned REFILL_BUBBLES = 1;

  localparam logic [9:0] B_SPC = 10'h200;
  localparam logic [9:0] B_SIF = 10'h100;
  localparam logic [9:0] B_SIE = 10'h080;
  localparam logic [9:0] B_SEM = 10'h040;
  localparam logic [9:0] B_FIF = 10'h020;
  localparam logic [9:0] B_FIE = 10'h010;
  localparam logic [9:0] B_FMW = 10'h008;
  localparam logic [9:0] B_RED = 10'h004;
  localparam logic [9:0] B_ERR = 10'h002;
  localparam logic [9:0] B_BSY = 10'h001;
  localparam logic [9:0] E_FRZ = B_SPC | B_SIF | B_SIE | B_SEM | B_FMW;
  localparam logic [9:0] E_LU  = B_SPC | B_SIF | B_FIE;
  localparam logic [9:0] E_MP  = B_RED | B_FIF | B_FIE;

  logic clk = 1'b0;
  logic i_reset, i_load_use, i_mispredict, i_dmem_req, i_dmem_ack;
  logic o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem;
  logic o_flush_if_id, o_flush_id_ex, o_flush_mem_wb;
  logic o_redirect, o_mem_err, o_busy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] o_cnt_load_use, o_cnt_mispredict, o_cnt_mem_wait;
`endif
  logic [9:0] outs;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit m_quiet_next = 1'b0;
  bit m_wait       = 1'b0;
  int m_waited     = 0;
  int m_refill     = 0;

  always #5 clk = ~clk;

  pipe_ctrl_sched #(
    .MEM_TIMEOUT   (MEM_TIMEOUT),
    .REFILL_BUBBLES(REFILL_BUBBLES)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_load_use    (i_load_use),
    .i_mispredict  (i_mispredict),
    .i_dmem_req    (i_dmem_req),
    .i_dmem_ack    (i_dmem_ack),
    .o_stall_pc    (o_stall_pc),
    .o_stall_if_id (o_stall_if_id),
    .o_stall_id_ex (o_stall_id_ex),
    .o_stall_ex_mem(o_stall_ex_mem),
    .o_flush_if_id (o_flush_if_id),
    .o_flush_id_ex (o_flush_id_ex),
    .o_flush_mem_wb(o_flush_mem_wb),
    .o_redirect    (o_redirect),
    .o_mem_err     (o_mem_err),
    .o_busy        (o_busy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_cnt_load_use  (o_cnt_load_use),
    .o_cnt_mispredict(o_cnt_mispredict),
    .o_cnt_mem_wait  (o_cnt_mem_wait)
`endif
  );

  assign outs = {o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem,
                 o_flush_if_id, o_flush_id_ex, o_flush_mem_wb,
                 o_redirect, o_mem_err, o_busy};

  typedef struct packed {
    logic       lu;
    logic       mp;
    logic       req;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [23];

  task automatic apply(input logic rst, input logic lu, input logic mp,
                       input logic req, input logic ack);
    @(negedge clk);
    i_reset      = rst;
    i_load_use   = lu;
    i_mispredict = mp;
    i_dmem_req   = req;
    i_dmem_ack   = ack;
    #2;
  endtask

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("reset_outputs", outs, 10'h000);
    end
  endtask

  // Behavioural reference: outputs for this cycle from the scheduling rules, then advance
  function automatic logic [9:0] model_step(input logic rst, input logic lu, input logic mp,
                                            input logic req, input logic ack);
    logic [9:0] e;
    e = '0;
    if (rst || m_quiet_next) begin
      m_quiet_next = rst;
      m_wait       = 1'b0;
      m_waited     = 0;
      m_refill     = 0;
      return e;
    end
    if (m_wait || m_refill > 0) e |= B_BSY;
    if (m_wait && !ack && m_waited == MEM_TIMEOUT - 1) begin
      e |= B_ERR;
      m_wait = 1'b0;
    end else if ((m_wait && !ack) || (!m_wait && req && !ack)) begin
      e |= E_FRZ;
      m_waited = m_wait ? m_waited + 1 : 0;
      m_wait   = 1'b1;
      m_refill = 0;
    end else begin
      m_wait = 1'b0;
      if (mp) begin
        e |= E_MP;
        m_refill = REFILL_BUBBLES;
      end else if (lu) begin
        e |= E_LU;
      end else if (m_refill > 0) begin
        e |= B_FIF;
        m_refill--;
      end
    end
    return e;
  endfunction

  initial begin
    logic [9:0] exp;
    logic rr, lu, mp, rq, ak;
    int ack_pct;

    vecs[0]  = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[1]  = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[2]  = '{lu:1, mp:0, req:0, ack:0, exp:E_LU};
    vecs[3]  = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[4]  = '{lu:0, mp:1, req:0, ack:0, exp:E_MP};
    vecs[5]  = '{lu:0, mp:0, req:0, ack:0, exp:B_FIF | B_BSY};
    vecs[6]  = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[7]  = '{lu:0, mp:0, req:1, ack:0, exp:E_FRZ};
    vecs[8]  = '{lu:0, mp:0, req:0, ack:0, exp:E_FRZ | B_BSY};
    vecs[9]  = '{lu:0, mp:0, req:0, ack:0, exp:E_FRZ | B_BSY};
    vecs[10] = '{lu:0, mp:0, req:0, ack:1, exp:B_BSY};
    vecs[11] = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[12] = '{lu:0, mp:0, req:0, ack:1, exp:10'h000};
    vecs[13] = '{lu:1, mp:1, req:0, ack:0, exp:E_MP};
    vecs[14] = '{lu:1, mp:0, req:0, ack:0, exp:E_LU | B_BSY};
    vecs[15] = '{lu:0, mp:0, req:0, ack:0, exp:B_FIF | B_BSY};
    vecs[16] = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};
    vecs[17] = '{lu:0, mp:0, req:1, ack:1, exp:10'h000};
    vecs[18] = '{lu:0, mp:1, req:1, ack:0, exp:E_FRZ};
    vecs[19] = '{lu:1, mp:1, req:0, ack:0, exp:E_FRZ | B_BSY};
    vecs[20] = '{lu:0, mp:1, req:0, ack:1, exp:E_MP | B_BSY};
    vecs[21] = '{lu:0, mp:0, req:0, ack:0, exp:B_FIF | B_BSY};
    vecs[22] = '{lu:0, mp:0, req:0, ack:0, exp:10'h000};

    i_reset = 1'b1; i_load_use = 1'b0; i_mispredict = 1'b0;
    i_dmem_req = 1'b0; i_dmem_ack = 1'b0;

    do_reset();
    for (int i = 0; i < 23; i++) begin
      apply(1'b0, vecs[i].lu, vecs[i].mp, vecs[i].req, vecs[i].ack);
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // watchdog: request never acknowledged
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wdog_c0", outs, E_FRZ);
    for (int i = 1; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("wdog_c%0d", i), outs, E_FRZ | B_BSY);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wdog_err", outs, B_ERR | B_BSY);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wdog_after", outs, 10'h000);

    // reset in the middle of a memory wait
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rstw_c0", outs, E_FRZ);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstw_c1", outs, E_FRZ | B_BSY);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstw_rst", outs, 10'h000);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rstw_idle", outs, 10'h000);
    end

    // reset in the middle of a refill
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rstr_mp", outs, E_MP);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstr_rst", outs, 10'h000);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstr_quiet", outs, 10'h000);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstr_idle", outs, 10'h000);

`ifdef PIPE_PERF_CNT_EN
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check32("cnt_load_use", o_cnt_load_use, 32'd5);
    check32("cnt_mispredict", o_cnt_mispredict, 32'd2);
    check32("cnt_mem_wait", o_cnt_mem_wait, 32'd3);
`endif

    // random stimulus against the reference model
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      exp = model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rand_reset", outs, exp);
    end
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 200) % 2 == 1) ? 40 : 4;
      rr = ($urandom_range(0, 199) == 0);
      lu = ($urandom_range(0, 99) < 20);
      mp = ($urandom_range(0, 99) < 12);
      rq = ($urandom_range(0, 99) < 25);
      ak = ($urandom_range(0, 99) < ack_pct);
      apply(rr, lu, mp, rq, ak);
      exp = model_step(rr, lu, mp, rq, ak);
      check($sformatf("rand%0d", i), outs, exp);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
